// File: rtl/modexp_engine_if.sv
// Request/response bundle for modexp_engine: operands and start/abort in, result and status out.
interface modexp_engine_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned EXP_WIDTH = 16
);
   logic                 start_in;
   logic                 abort_in;
   logic [WIDTH-1:0]     value_in;
   logic [EXP_WIDTH-1:0] exponent_in;
   logic [WIDTH-1:0]     modulus_in;
   logic [WIDTH-1:0]     value_out;
   logic                 busy_out;
   logic                 valid_out;
   logic                 error_out;

   modport master (
      output start_in, abort_in, value_in, exponent_in, modulus_in,
      input  value_out, busy_out, valid_out, error_out
   );

   modport slave (
      input  start_in, abort_in, value_in, exponent_in, modulus_in,
      output value_out, busy_out, valid_out, error_out
   );
endinterface

// File: rtl/modexp_engine.sv
// Right-to-left square-and-multiply modular exponentiation built around one
// bit-serial interleaved modular multiplier (one multiplier bit per clock).
module modexp_engine #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned EXP_WIDTH = 16
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   modexp_engine_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = WIDTH + 1;

   typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, DONE} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     val_q, val_d;
   logic [WIDTH-1:0]     mod_q, mod_d;
   logic [WIDTH-1:0]     base_q, base_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic [PW-1:0]        p_q, p_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic [WIDTH-1:0]     mul_a, mul_b;
   logic [PW-1:0]        m_ext, dbl, red1, sum, p_next;
   logic [EXP_WIDTH-1:0] exp_sh;
   logic                 last_bit, higher;

   // One interleaved multiplier step: P = 2P mod m, then P = (P + a[i]*b) mod m.
   always_comb begin
      mul_a = base_q;
      mul_b = acc_q;
      case (state_q)
         REDUCE: begin
            mul_a = val_q;
            mul_b = WIDTH'(1);
         end
         SQR:     mul_b = base_q;
         default: ;
      endcase
      m_ext    = {1'b0, mod_q};
      dbl      = {p_q[WIDTH-1:0], 1'b0};
      red1     = (dbl >= m_ext) ? dbl - m_ext : dbl;
      sum      = mul_a[cnt_q] ? red1 + {1'b0, mul_b} : red1;
      p_next   = (sum >= m_ext) ? sum - m_ext : sum;
      last_bit = (cnt_q == '0);
      exp_sh   = exp_q >> 1;
      higher   = |exp_sh;
   end

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      mod_d   = mod_q;
      exp_d   = exp_q;
      base_d  = base_q;
      acc_d   = acc_q;
      res_d   = res_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      err_d   = err_q;
      busy_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_in) begin
               val_d = bus.value_in;
               exp_d = bus.exponent_in;
               mod_d = bus.modulus_in;
               err_d = 1'b0;
               p_d   = '0;
               cnt_d = CW'(WIDTH - 1);
               // Degenerate operands finish without ever going busy.
               if (bus.modulus_in == '0) begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  valid_d = 1'b1;
               end else if (bus.modulus_in == WIDTH'(1)) begin
                  res_d   = '0;
                  valid_d = 1'b1;
               end else if (bus.exponent_in == '0) begin
                  res_d   = WIDTH'(1);
                  valid_d = 1'b1;
               end else begin
                  state_d = REDUCE;
               end
            end
         end
         REDUCE, MUL, SQR: begin
            p_d   = p_next;
            cnt_d = cnt_q - CW'(1);
            if (last_bit) begin
               p_d   = '0;
               cnt_d = CW'(WIDTH - 1);
               case (state_q)
                  REDUCE: begin
                     base_d  = p_next[WIDTH-1:0];
                     acc_d   = WIDTH'(1);
                     state_d = exp_q[0] ? MUL : SQR;
                  end
                  MUL: begin
                     acc_d = p_next[WIDTH-1:0];
                     if (higher) begin
                        state_d = SQR;
                     end else begin
                        state_d = DONE;
                        res_d   = p_next[WIDTH-1:0];
                        valid_d = 1'b1;
                     end
                  end
                  default: begin
                     // Zero exponent bits are skipped by squaring again directly.
                     base_d  = p_next[WIDTH-1:0];
                     exp_d   = exp_sh;
                     state_d = exp_sh[0] ? MUL : SQR;
                  end
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (bus.abort_in && (state_q != IDLE)) begin
         state_d = IDLE;
         valid_d = 1'b0;
         res_d   = res_q;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         val_q   <= '0;
         mod_q   <= '0;
         exp_q   <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         mod_q   <= mod_d;
         exp_q   <= exp_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.value_out = res_q;
   assign bus.busy_out  = busy_q;
   assign bus.valid_out = valid_q;
   assign bus.error_out = err_q;
endmodule

// File: tb/tb_modexp_engine.sv
// Randomized self-checking bench for modexp_engine against an arithmetic reference.
module tb_modexp_engine;
   localparam int unsigned W  = 16;
   localparam int unsigned EW = 16;

   logic clk = 1'b0;
   logic rst_n;

   modexp_engine_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();
   modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Plain modular exponentiation with native arithmetic.
   function automatic longint ref_modexp(input longint v, input longint e, input longint m);
      longint r, b, x;
      if (m < 2) return 0;
      r = 1;
      b = v % m;
      x = e;
      while (x > 0) begin
         if (x % 2 == 1) r = (r * b) % m;
         b = (b * b) % m;
         x = x / 2;
      end
      return r;
   endfunction

   function automatic int ref_latency(input longint e, input longint m);
      int pc, lg;
      if (m < 2 || e == 0) return 1;
      pc = 0;
      lg = 0;
      for (int i = 0; i < 64; i++) begin
         if ((e >> i) % 2 == 1) begin
            pc++;
            lg = i;
         end
      end
      return W * (1 + pc + lg) + 1;
   endfunction

   // Issue one start, then watch cycles 1..budget (stops 3 cycles after valid).
   task automatic run_job(input logic [W-1:0] v, input logic [EW-1:0] e, input logic [W-1:0] m,
                          input int poke_at, input int abort_at, input int budget,
                          output int lat, output int busy_n, output int valid_n,
                          output logic [W-1:0] val, output logic err);
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.value_in    = v;
      bus.exponent_in = e;
      bus.modulus_in  = m;
      bus.abort_in    = (abort_at == 0);
      lat = -1; busy_n = 0; valid_n = 0; val = '0; err = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (bus.busy_out) busy_n++;
         if (bus.valid_out) begin
            valid_n++;
            if (lat < 0) begin
               lat = k;
               val = bus.value_out;
               err = bus.error_out;
            end
         end
         bus.start_in    = (k == poke_at);
         bus.abort_in    = (k == abort_at);
         bus.value_in    = W'($urandom);
         bus.exponent_in = EW'($urandom);
         bus.modulus_in  = W'($urandom);
         if (lat > 0 && k >= lat + 3) break;
      end
      bus.start_in = 1'b0;
      bus.abort_in = 1'b0;
   endtask

   task automatic do_case(input string tag, input logic [W-1:0] v, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input int poke_at, input bit abort0,
                          output int lat, output logic [W-1:0] val);
      int   exp_lat, busy_n, valid_n;
      logic err;
      bit   degen;
      exp_lat = ref_latency(e, m);
      degen   = (m < 2) || (e == 0);
      run_job(v, e, m, poke_at, abort0 ? 0 : -1, exp_lat + 10, lat, busy_n, valid_n, val, err);
      check_eq({tag, "_val"}, val, ref_modexp(v, e, m));
      check_eq({tag, "_err"}, err, m == 0);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_nvalid"}, valid_n, 1);
      check_eq({tag, "_busy"}, busy_n, degen ? 0 : exp_lat);
   endtask

   initial begin
      int            lat, busy_n, valid_n;
      logic [W-1:0]  val, v, m;
      logic [EW-1:0] e;
      logic          err;
      int            ew;
      logic [63:0]   mask;

      rst_n           = 1'b0;
      bus.start_in    = 1'b0;
      bus.abort_in    = 1'b0;
      bus.value_in    = '0;
      bus.exponent_in = '0;
      bus.modulus_in  = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_value", bus.value_out, 0);
      check_eq("rst_busy", bus.busy_out, 0);
      check_eq("rst_valid", bus.valid_out, 0);
      check_eq("rst_error", bus.error_out, 0);
      rst_n = 1'b1;

      do_case("pow4_13", 16'd4, 16'd13, 16'd497, -1, 1'b0, lat, val);
      check_eq("pow4_13_const_val", val, 445);
      check_eq("pow4_13_const_lat", lat, 113);
      do_case("base_ge_m", 16'd1000, 16'd3, 16'd13, -1, 1'b0, lat, val);
      check_eq("base_ge_m_const", val, 12);
      do_case("carmichael", 16'd7, 16'd560, 16'd561, -1, 1'b0, lat, val);
      check_eq("carmichael_const", val, 1);

      do_case("deg_e0", 16'd3, 16'd0, 16'd7, -1, 1'b0, lat, val);
      check_eq("deg_e0_const", val, 1);
      do_case("deg_m1", 16'd5, 16'd9, 16'd1, -1, 1'b0, lat, val);
      check_eq("deg_m1_const", val, 0);
      do_case("deg_m0", 16'd9, 16'd5, 16'd0, -1, 1'b0, lat, val);
      check_eq("deg_m0_err", bus.error_out, 1);

      do_case("start_busy", 16'd4, 16'd13, 16'd497, 20, 1'b0, lat, val);
      check_eq("start_busy_const", val, 445);

      run_job(16'd4, 16'd13, 16'd497, -1, 40, 150, lat, busy_n, valid_n, val, err);
      check_eq("abort_nvalid", valid_n, 0);
      check_eq("abort_busy", busy_n, 40);
      check_eq("abort_hold_val", bus.value_out, 445);
      check_eq("abort_hold_err", bus.error_out, 0);
      do_case("after_abort", 16'd2, 16'd10, 16'd1000, -1, 1'b0, lat, val);
      check_eq("after_abort_const", val, 24);
      do_case("abort_with_start", 16'd4, 16'd13, 16'd497, -1, 1'b1, lat, val);

      // Reset asserted between edges while squaring (cycle 40 of the 4^13 job).
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.value_in    = 16'd4;
      bus.exponent_in = 16'd13;
      bus.modulus_in  = 16'd497;
      @(negedge clk);
      bus.start_in = 1'b0;
      repeat (39) @(negedge clk);
      check_eq("pre_rst_busy", bus.busy_out, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_value", bus.value_out, 0);
      check_eq("arst_busy", bus.busy_out, 0);
      check_eq("arst_valid", bus.valid_out, 0);
      check_eq("arst_error", bus.error_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_case("post_rst", 16'd4, 16'd13, 16'd497, -1, 1'b0, lat, val);
      check_eq("post_rst_const", val, 445);

      for (int n = 0; n < 300; n++) begin
         v = W'($urandom);
         case ($urandom_range(0, 9))
            0:       m = '0;
            1:       m = W'(1);
            2, 3:    m = W'($urandom_range(2, 30));
            default: m = W'($urandom);
         endcase
         ew   = ($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(0, 12));
         mask = (64'd1 << ew) - 64'd1;
         e    = EW'(64'($urandom) & mask);
         do_case("rand", v, e, m, -1, ($urandom_range(0, 7) == 0), lat, val);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
